// File: rtl/dprob_seq_ctrl.sv
// dprob_seq_ctrl: sequencer and credit-based flow controller for the
// dprob_process datapath. Groups input beats per bounding box, issues them
// to the non-stallable datapath, buffers the results in a FIFO and re-emits
// them as an AXI-stream tagged with beat index and group end.
// Optional feature macro: DPROB_PERF_CNT_EN (group and stall counters).
// FLUSH_CYCLES is expected to be at least 1.
`timescale 1ns/1ps
module dprob_seq_ctrl #(
  parameter int BEATS_PER_GROUP = 5,
  parameter int FIFO_DEPTH      = 16,
  parameter int FLUSH_CYCLES    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               err_clr,
  input  logic [63:0]                        s_tdata,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  input  logic                               s_tlast,
  output logic [63:0]                        dp_data,
  output logic                               dp_valid,
  output logic                               dp_first_set,
  input  logic [15:0]                        dp_max,
  input  logic [15:0]                        dp_min,
  input  logic [15:0]                        dp_sum,
  input  logic                               dp_valid_out,
  output logic [47:0]                        m_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast,
  output logic [$clog2(BEATS_PER_GROUP)-1:0] m_tuser,
  output logic                               busy,
  output logic                               err_len,
  output logic                               err_ovf,
  output logic [31:0]                        perf_groups,
  output logic [31:0]                        perf_stall
);

  localparam int IDX_W = $clog2(BEATS_PER_GROUP);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam int ENT_W = 48 + IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_GROUP - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   beat_cnt;
  logic [IDX_W-1:0]   out_idx;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   credit;
  logic [FL_W-1:0]    flush_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tag_wr;
  logic [PTR_W-1:0]   tag_rd;
  logic [ENT_W-1:0]   res_mem [FIFO_DEPTH];
  logic               tag_mem [FIFO_DEPTH];

  logic hs;
  logic beat_last;
  logic group_end;
  logic len_evt;
  logic flushing;
  logic res_evt;
  logic res_take;
  logic fifo_full;
  logic push;
  logic pop;
  logic ovf_evt;
  logic tag_end;
  logic head_avail;

  // Credits cover both buffered and in-flight results, so an accepted beat
  // always has a FIFO slot waiting for its result.
  assign credit    = DEPTH_C - fifo_count - inflight;
  assign s_tready  = (state == RUN) && (credit != '0);
  assign hs        = s_tvalid && s_tready;
  assign beat_last = (beat_cnt == LAST_IDX);
  assign group_end = hs && (beat_last || s_tlast);
  assign len_evt   = hs && (s_tlast != beat_last);

  // The datapath has no reset, so its strobe is meaningless until flushed.
  assign flushing  = (flush_cnt != '0);
  assign res_evt   = dp_valid_out && !flushing;
  assign res_take  = res_evt && (inflight != '0);
  assign pop       = m_tvalid && m_tready;
  assign fifo_full = (fifo_count == DEPTH_C);
  assign push      = res_take && (!fifo_full || pop);
  assign ovf_evt   = res_evt && !push;
  assign tag_end   = tag_mem[tag_rd];

  // Next head of the FIFO as seen from the output register; entries written
  // on this edge are not yet visible and are picked up on the next one.
  assign head_ptr   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign head_avail = (fifo_count - CNT_W'(pop)) != '0;

  assign busy = (state != IDLE) || (inflight != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; enable is only acted on at group boundaries in RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && !flushing) state_next = RUN;
      RUN:     if (group_end && !enable) state_next = DRAIN;
      DRAIN:   if ((inflight == '0) && (fifo_count == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue registers towards the datapath and the input-side beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_data      <= '0;
      dp_valid     <= 1'b0;
      dp_first_set <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      dp_valid     <= hs;
      dp_first_set <= hs && (beat_cnt == '0);
      if (hs) begin
        dp_data  <= s_tdata;
        beat_cnt <= group_end ? '0 : beat_cnt + IDX_W'(1);
      end
    end
  end

  // In-flight count, group-end tag queue pointers and result-side index.
  // Tags are queued in issue order so early-terminated groups realign too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      out_idx  <= '0;
    end else begin
      case ({hs, res_take})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (hs) tag_wr <= tag_wr + PTR_W'(1);
      if (res_take) begin
        tag_rd  <= tag_rd + PTR_W'(1);
        out_idx <= tag_end ? '0 : out_idx + IDX_W'(1);
      end
    end
  end

  // Storage for result entries and group-end tags; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) res_mem[wr_ptr] <= {dp_max, dp_min, dp_sum, out_idx, out_idx == LAST_IDX};
    if (hs)   tag_mem[tag_wr] <= group_end;
  end

  // Result FIFO pointers and occupancy; the displayed head stays counted
  // until it is accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered output stage; reloads only when empty or being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
    end else if (!m_tvalid || pop) begin
      m_tvalid <= head_avail;
      if (head_avail) {m_tdata, m_tuser, m_tlast} <= res_mem[head_ptr];
    end
  end

  // Sticky error flags; a new event outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_len <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_len <= len_evt || (err_len && !err_clr);
      err_ovf <= ovf_evt || (err_ovf && !err_clr);
    end
  end

  // Post-reset flush window that masks stale datapath strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flush_cnt <= FL_W'(FLUSH_CYCLES);
    else if (flushing) flush_cnt <= flush_cnt - FL_W'(1);
  end

`ifdef DPROB_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = (state == RUN) && s_tvalid && !s_tready;

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_groups <= '0;
      perf_stall  <= '0;
    end else begin
      if (group_end && (perf_groups != '1))  perf_groups <= perf_groups + 32'd1;
      if (stall_cycle && (perf_stall != '1)) perf_stall  <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_groups = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: doc/dprob_seq_ctrl.md
Name: dprob_seq_ctrl

Overview:
- Sequencer and flow controller in front of the dprob_process datapath (pairwise fp16 sum, max and min over 4 lanes per beat).
- Accepts class-probability beats from an AXI-stream source and groups them into fixed-size groups per bounding box.
- Drives the datapath's data, valid and first-set strobe, and uses credits so the non-stallable datapath can never overrun the result buffer.
- Buffers datapath results in a FIFO and re-emits them as an AXI-stream, tagged with beat index and group end.

Parameters:
- BEATS_PER_GROUP, 5: 64-bit beats per group (20 fp16 probabilities); must be at least 2.
- FIFO_DEPTH, 16: result FIFO entries; power of 2, at least 4.
- FLUSH_CYCLES, 16: cycles after reset release during which dp_valid_out is ignored (the datapath has no reset).

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- enable in 1: run request; sampled at group boundaries.
- err_clr in 1: clears the sticky error flags.
- s_tdata in 64: 4 fp16 probabilities; lane 0 is [15:0].
- s_tvalid in 1: input valid.
- s_tready out 1: input ready.
- s_tlast in 1: last beat of a group.
- dp_data out 64: datapath data, registered.
- dp_valid out 1: datapath valid, registered.
- dp_first_set out 1: high with beat 0 of each group.
- dp_max in 16: datapath max result.
- dp_min in 16: datapath min result.
- dp_sum in 16: datapath sum result.
- dp_valid_out in 1: datapath result strobe.
- m_tdata out 48: result as {max, min, sum}.
- m_tvalid out 1: result valid.
- m_tready in 1: result ready.
- m_tlast out 1: result belongs to the last beat of its group.
- m_tuser out clog2(BEATS_PER_GROUP): beat index within the group.
- busy out 1: high when state is not IDLE or inflight is nonzero.
- err_len out 1: sticky group-length error.
- err_ovf out 1: sticky overflow or spurious-result error.
- perf_groups out 32: groups issued (optional feature).
- perf_stall out 32: stall cycles (optional feature).

Behaviour:
- Reset values: s_tready, dp_valid, dp_first_set, m_tvalid, m_tlast, busy, err_len, err_ovf all 0; dp_data, m_tdata, m_tuser 0; FSM in IDLE; all counters 0; flush counter loaded with FLUSH_CYCLES.
- State IDLE:
  - s_tready=0.
  - Go to RUN when enable=1 and the flush counter is 0.
- State RUN:
  - s_tready = (credit > 0), where credit = FIFO_DEPTH - fifo_count - inflight.
  - On handshake: dp_data <= s_tdata; dp_valid <= 1 in the next cycle (1-cycle issue latency).
  - dp_first_set <= (beat_cnt == 0).
  - beat_cnt increments and wraps to 0 after BEATS_PER_GROUP-1.
- Group end in RUN:
  - Group end is a handshake with beat_cnt == BEATS_PER_GROUP-1, or with s_tlast=1.
  - At group end: beat_cnt <= 0.
  - If enable=0 at group end, go to DRAIN; otherwise stay in RUN.
- State DRAIN:
  - s_tready=0.
  - Go to IDLE when inflight == 0 and the FIFO is empty.
- Length check: set err_len if s_tlast=1 with beat_cnt != BEATS_PER_GROUP-1, or s_tlast=0 with beat_cnt == BEATS_PER_GROUP-1. In both cases beat_cnt still resyncs to 0.
- Inflight counter:
  - +1 on issue, -1 on dp_valid_out; no change when both occur in the same cycle.
  - Width is clog2(FIFO_DEPTH)+1.
- Result capture:
  - On dp_valid_out, push {dp_max, dp_min, dp_sum, out_idx, out_idx == BEATS_PER_GROUP-1}.
  - out_idx is a separate beat counter on the result side, reset to 0 at group end.
  - Result tags follow issue order: the datapath is in-order and has a fixed latency.
- Spurious results:
  - dp_valid_out with inflight == 0, or with the FIFO full, is dropped and sets err_ovf.
  - Credit accounting makes the FIFO-full case unreachable in correct operation.
- Flush window: while the flush counter is nonzero, dp_valid_out is ignored and sets no error.
- Output side:
  - m_* is a registered FIFO head.
  - A result appears on m_* no earlier than 1 cycle after its dp_valid_out.
  - m_* is held stable while m_tvalid=1 and m_tready=0.
- FIFO push and pop in the same cycle:
  - Both take effect and fifo_count is unchanged.
  - A push into a full FIFO is allowed when a pop occurs in the same cycle.
- Errors: err_clr clears both sticky flags; a new error event in the same cycle wins (the flag stays set).
- Reset mid-operation: all state is discarded; in-flight datapath results are absorbed by the flush window.

Optional Feature:
- Macro: DPROB_PERF_CNT_EN.
- Defined:
  - perf_groups increments at every group end.
  - perf_stall increments each cycle with state == RUN, s_tvalid=1 and s_tready=0.
  - Both saturate at 0xFFFFFFFF and are cleared by reset only.
- Undefined: perf_groups and perf_stall are tied to 0 and no counter logic is built.

Test Plan:
- Basic group: reset, wait flush, enable=1; send 5 beats with s_tlast on beat 4 and m_tready=1 → dp_first_set high only with beat 0; 5 results with m_tuser 0..4; m_tlast only on index 4; err_len=0.
- Backpressure: m_tready=0 with a continuous source → exactly 16 beats accepted, then s_tready=0; release m_tready → all 16 results in order, err_ovf=0.
- Length error: s_tlast on beat 2 → err_len=1; next beat has dp_first_set=1; err_clr → err_len=0.
- Drain: drop enable mid-group (beat 1) → group finishes (beats 2..4 accepted), then s_tready=0; busy falls after the last result pops; state IDLE.
- Reset mid-run: assert rst_n low with 3 beats inflight → all outputs 0; datapath results arriving within 16 cycles are ignored, err_ovf=0; a subsequent spurious dp_valid_out sets err_ovf=1.
- With DPROB_PERF_CNT_EN: 3 groups with 4 stall cycles → perf_groups=3, perf_stall=4; without the macro both read 0.
